// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// fetch stage (read only) and the memory stage (read/write).
//
// Each access runs Idle -> Access (MEM_LATENCY cycles) -> Done (one cycle). The
// owner, address, write flag and store data are latched in Idle, so the memory
// bus never sees a combinational path from the request inputs.
//
// Build option: define MEM_PORT_ARBITER_RR_EN for round-robin arbitration when
// both ports request together; by default the data port always wins.

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // Access cycles are counted down to zero, so the load value is one less.
  localparam logic [3:0] CountInit = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              owner_q, owner_d;  // 1: data port owns the access
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic              grant_dm;
  logic              owner_req;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_q, last_d;  // last owner, 1: data port

  // Contended requests go to the port that did not own the previous access.
  always_comb begin
    grant_dm = dm_req & (~if_req | ~last_q);
  end

  // Last-owner register, starts as if fetch had just been served.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Data port has fixed priority so the older instruction always drains.
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  // Request level of whichever port owns the access in flight.
  always_comb begin
    owner_req = owner_q ? dm_req : if_req;
  end

  // Next-state, transaction latch and read-data capture.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
`ifdef MEM_PORT_ARBITER_RR_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (if_req || dm_req) begin
          owner_d = grant_dm;
          // Fetch never writes, whatever dm_wr happens to be.
          wr_d    = grant_dm & dm_wr;
          addr_d  = grant_dm ? dm_addr : if_addr;
          wdata_d = grant_dm ? dm_wdata : '0;
          count_d = CountInit;
          state_d = StAccess;
`ifdef MEM_PORT_ARBITER_RR_EN
          last_d  = grant_dm;
`endif
        end
      end

      StAccess: begin
        // Dropping the request mid-access is a protocol error; the access
        // still completes because a write cannot be recalled.
        if (!owner_req) begin
          err_d = 1'b1;
        end
        if (count_q == 4'd0) begin
          if (!wr_q) begin
            if (owner_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
          state_d = StDone;
        end else begin
          count_d = count_q - 4'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode from registered state; only the stalls see the requests.
  always_comb begin
    mem_en    = (state_q == StAccess);
    mem_wr    = (state_q == StAccess) & wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_done   = (state_q == StDone) & ~owner_q;
    dm_done   = (state_q == StDone) & owner_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    err       = err_q;
    if_stall  = if_req & ~if_done;
    dm_stall  = dm_req & ~dm_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbiter.

module tb_mem_port_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LATENCY(L),
    .ADDR_W     (16),
    .DATA_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Transaction model: one access at a time, occupying a window of cycles.
  bit          m_busy;
  int          m_start, m_end, m_done;
  bit          m_owner;  // 1: data port
  bit          m_wr;
  logic [15:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
  bit          m_err, m_last;
  logic        prev_if_done, prev_dm_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_if_rd = '0;
    m_dm_rd = '0;
    m_err   = 1'b0;
    m_last  = 1'b0;
  endtask

  // Check this cycle's outputs against the model, then advance the model.
  task automatic model_step();
    bit en, ifd, dmd, gdm;
    en  = m_busy && cyc >= m_start && cyc <= m_end;
    ifd = m_busy && cyc == m_done && !m_owner;
    dmd = m_busy && cyc == m_done && m_owner;
    chk("mem_en", 32'(mem_en), 32'(en));
    chk("mem_wr", 32'(mem_wr), 32'(en && m_wr));
    if (en) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (en && m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("if_done", 32'(if_done), 32'(ifd));
    chk("dm_done", 32'(dm_done), 32'(dmd));
    chk("if_rdata", 32'(if_rdata), 32'(m_if_rd));
    chk("dm_rdata", 32'(dm_rdata), 32'(m_dm_rd));
    chk("err", 32'(err), 32'(m_err));
    chk("if_stall", 32'(if_stall), 32'(if_req && !ifd));
    chk("dm_stall", 32'(dm_stall), 32'(dm_req && !dmd));
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      if (en && !(m_owner ? dm_req : if_req)) m_err = 1'b1;
      if (cyc == m_end && !m_wr) begin
        if (m_owner) m_dm_rd = mem_rdata;
        else m_if_rd = mem_rdata;
      end
      if (cyc == m_done) m_busy = 1'b0;
    end else if (if_req || dm_req) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      gdm = dm_req && (!if_req || !m_last);
`else
      gdm = dm_req;
`endif
      m_owner = gdm;
      m_last  = gdm;
      m_wr    = gdm && dm_wr;
      m_addr  = gdm ? dm_addr : if_addr;
      m_wdata = dm_wdata;
      m_start = cyc + 1;
      m_end   = cyc + L;
      m_done  = cyc + L + 1;
      m_busy  = 1'b1;
    end
    cyc++;
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+2.
  task automatic tick();
    #1;
    prev_if_done = if_done;
    prev_dm_done = dm_done;
    model_step();
    @(posedge clk);
    #1;
  endtask

  int n_if, n_dm;

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_dm_rdata", 32'(dm_rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();

    // 1: single fetch read
    for (int c = 0; c <= 6; c++) begin
      if_req = (c <= 5); if_addr = 16'h0010; mem_rdata = 16'hBEEF;
      #1;
      if (c >= 1 && c <= 4) chk("t1_addr", 32'(mem_addr), 32'h0010);
      if (c <= 4) chk("t1_stall", 32'(if_stall), 32'd1);
      if (c == 5) chk("t1_done", 32'(if_done), 32'd1);
      if (c == 5) chk("t1_rdata", 32'(if_rdata), 32'hBEEF);
      tick();
    end

    // 2: simultaneous requests, data port served first
    for (int c = 0; c <= 12; c++) begin
      if_req = (c <= 11); if_addr = 16'h0020;
      dm_req = (c <= 5); dm_wr = 1'b0; dm_addr = 16'h0100;
      mem_rdata = (c <= 6) ? 16'hC0DE : 16'h5A5A;
      #1;
      if (c == 5) chk("t2_dm_done", 32'(dm_done), 32'd1);
      if (c == 7) chk("t2_if_addr", 32'(mem_addr), 32'h0020);
      if (c == 11) chk("t2_if_done", 32'(if_done), 32'd1);
      if (c == 11) chk("t2_if_rdata", 32'(if_rdata), 32'h5A5A);
      if (c <= 10) chk("t2_if_stall", 32'(if_stall), 32'd1);
      tick();
    end

    // 3: store leaves dm_rdata alone
    for (int c = 0; c <= 6; c++) begin
      dm_req = (c <= 5); dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
      mem_rdata = 16'hFFFF;
      #1;
      if (c == 3) chk("t3_wr", 32'(mem_wr), 32'd1);
      if (c == 3) chk("t3_wdata", 32'(mem_wdata), 32'h1234);
      if (c == 5) chk("t3_done", 32'(dm_done), 32'd1);
      if (c == 5) chk("t3_rdata", 32'(dm_rdata), 32'hC0DE);
      tick();
    end
    dm_wr = 1'b0;

    // 4: reset in the middle of a fetch access
    for (int c = 0; c <= 8; c++) begin
      if_req = (c <= 2); if_addr = 16'h0030; rst = (c == 2); mem_rdata = 16'h7777;
      #1;
      if (c == 3) chk("t4_mem_en", 32'(mem_en), 32'd0);
      if (c == 3) chk("t4_if_rdata", 32'(if_rdata), 32'd0);
      if (c >= 3) chk("t4_no_done", 32'(if_done), 32'd0);
      tick();
    end

    // 5: owner drops its request mid-read
    for (int c = 0; c <= 7; c++) begin
      dm_req = (c <= 1); dm_addr = 16'h0050; mem_rdata = 16'h9999;
      #1;
      if (c >= 3) chk("t5_err", 32'(err), 32'd1);
      if (c == 5) chk("t5_done", 32'(dm_done), 32'd1);
      if (c == 6) chk("t5_rdata", 32'(dm_rdata), 32'h9999);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_err_clear", 32'(err), 32'd0);
    tick();

    // 6: both ports hold their requests continuously
    n_if = 0; n_dm = 0;
    for (int c = 0; c <= 23; c++) begin
      if_req = 1'b1; if_addr = 16'h0060; dm_req = 1'b1; dm_addr = 16'h0070;
      mem_rdata = 16'(c);
      #1;
      if (if_done) n_if++;
      if (dm_done) n_dm++;
      tick();
    end
`ifdef MEM_PORT_ARBITER_RR_EN
    chk("t6_if_grants", 32'(n_if), 32'd2);
    chk("t6_dm_grants", 32'(n_dm), 32'd2);
`else
    chk("t6_if_grants", 32'(n_if), 32'd0);
    chk("t6_dm_grants", 32'(n_dm), 32'd4);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Random traffic from protocol-abiding requesters with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (if_req && prev_if_done) if_req = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom);
      end
      if (dm_req && prev_dm_done) dm_req = 1'b0;
      if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_wr = 1'($urandom); dm_addr = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      mem_rdata = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
